// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the five-stage pipeline.
// Owns the PC, issues instruction-memory requests and loads the IF/ID
// register. A one-entry skid buffer absorbs an instruction acknowledged
// while Decode is stalled; a pending redirect is held while an outstanding
// memory request drains so the memory never sees its address change.
//
// Ports:
//   clock, reset            - clock; synchronous active-high reset
//   fw_if_id_stall          - load-use stall: hold IF/ID and the PC
//   ex_if_branch/_target    - taken redirect from Execute (one-cycle pulse)
//   if_imem_req/_addr       - instruction-memory request, address = pc
//   imem_if_ack/_data       - one-cycle acknowledge with instruction
//   if_id_instruc/_pc4/_valid - IF/ID register toward Decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fw_if_id_stall,
  input  logic        ex_if_branch,
  input  logic [31:0] ex_if_target,
  output logic        if_imem_req,
  output logic [31:0] if_imem_addr,
  input  logic        imem_if_ack,
  input  logic [31:0] imem_if_data,
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  assign if_imem_req   = (state_q == FETCH || state_q == DRAIN) && !reset;
  assign if_imem_addr  = pc_q;
  assign if_id_instruc = instr_q;
  assign if_id_pc4     = pc4_q;
  assign if_id_valid   = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redirect_d  = redirect_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    case (state_q)
      FETCH: begin
        if (ex_if_branch) begin
          // Flush wins over stall; pc4 is meaningless once invalid.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (imem_if_ack) begin
            pc_d = ex_if_target;              // data for old path dropped
          end else begin
            redirect_d = ex_if_target;        // wait for in-flight request
            state_d    = DRAIN;
          end
        end else if (imem_if_ack) begin
          pc_d = pc_plus4;
          if (fw_if_id_stall) begin
            buf_instr_d = imem_if_data;
            buf_pc4_d   = pc_plus4;
            state_d     = HOLD;
          end else begin
            instr_d = imem_if_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!fw_if_id_stall) begin
          instr_d = NOP_INSTR;                // bubble while memory waits
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (ex_if_branch) begin
          pc_d    = ex_if_target;             // buffered instr is wrong-path
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!fw_if_id_stall) begin
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (imem_if_ack) begin
          pc_d    = ex_if_branch ? ex_if_target : redirect_q;
          state_d = FETCH;
        end else if (ex_if_branch) begin
          redirect_d = ex_if_target;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      redirect_q  <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      instr_q     <= NOP_INSTR;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redirect_q  <= redirect_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The memory model acknowledges
// combinationally whenever ack_gate is set and a request is up, returning
// addr ^ 32'hA5A5_0000. Each table row gives the inputs for one cycle and
// the outputs expected in that same cycle (before the edge).
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock, reset, stall, branch, ack_gate, force_ack;
  logic [31:0] target;
  logic        req, ack, valid;
  logic [31:0] addr, data, instr, pc4;
  logic        req2, ack2, valid2;
  logic [31:0] addr2, data2, instr2, pc42;

  assign ack   = (ack_gate & req) | force_ack;
  assign data  = addr ^ KEY;
  assign ack2  = (ack_gate & req2) | force_ack;
  assign data2 = addr2 ^ KEY;

  fetch_stage dut (
    .clock(clock), .reset(reset), .fw_if_id_stall(stall),
    .ex_if_branch(branch), .ex_if_target(target),
    .if_imem_req(req), .if_imem_addr(addr),
    .imem_if_ack(ack), .imem_if_data(data),
    .if_id_instruc(instr), .if_id_pc4(pc4), .if_id_valid(valid));

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut2 (
    .clock(clock), .reset(reset), .fw_if_id_stall(stall),
    .ex_if_branch(branch), .ex_if_target(target),
    .if_imem_req(req2), .if_imem_addr(addr2),
    .imem_if_ack(ack2), .imem_if_data(data2),
    .if_id_instruc(instr2), .if_id_pc4(pc42), .if_id_valid(valid2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst, st, br;
    logic [31:0] tgt;
    logic        ackg, fack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
    logic        c_pc4;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[25];

  function automatic logic [31:0] d(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  function automatic vec_t row(input logic rst, st, br, input logic [31:0] tgt,
                               input logic ackg, fack, e_req,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_instr, e_pc4,
                               input logic c_pc4);
    vec_t v;
    v.rst = rst; v.st = st; v.br = br; v.tgt = tgt; v.ackg = ackg; v.fack = fack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc4 = e_pc4; v.c_pc4 = c_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //          rst st br tgt      ack fa  req addr     v  instr          pc4      cpc4
    tbl[0]  = row(1, 0, 0, 32'h0,   1, 0,  0, 32'h0,   0, 32'h0,         32'h0,   1);
    tbl[1]  = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h0,   0, 32'h0,         32'h0,   1);
    tbl[2]  = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h4,   1, d(32'h0),      32'h4,   1);
    tbl[3]  = row(0, 1, 0, 32'h0,   1, 0,  1, 32'h8,   1, d(32'h4),      32'h8,   1);
    tbl[4]  = row(0, 1, 0, 32'h0,   1, 0,  0, 32'hC,   1, d(32'h4),      32'h8,   1);
    tbl[5]  = row(0, 1, 0, 32'h0,   1, 0,  0, 32'hC,   1, d(32'h4),      32'h8,   1);
    tbl[6]  = row(0, 0, 0, 32'h0,   1, 0,  0, 32'hC,   1, d(32'h4),      32'h8,   1);
    tbl[7]  = row(0, 0, 0, 32'h0,   1, 0,  1, 32'hC,   1, d(32'h8),      32'hC,   1);
    tbl[8]  = row(0, 0, 1, 32'h100, 1, 0,  1, 32'h10,  1, d(32'hC),      32'h10,  1);
    tbl[9]  = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h100, 0, 32'h0,         32'h0,   0);
    tbl[10] = row(0, 0, 1, 32'h200, 0, 0,  1, 32'h104, 1, d(32'h100),    32'h104, 1);
    tbl[11] = row(0, 0, 0, 32'h0,   0, 0,  1, 32'h104, 0, 32'h0,         32'h0,   0);
    tbl[12] = row(0, 0, 0, 32'h0,   0, 0,  1, 32'h104, 0, 32'h0,         32'h0,   0);
    tbl[13] = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h104, 0, 32'h0,         32'h0,   0);
    tbl[14] = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h200, 0, 32'h0,         32'h0,   0);
    tbl[15] = row(0, 1, 0, 32'h0,   1, 0,  1, 32'h204, 1, d(32'h200),    32'h204, 1);
    tbl[16] = row(0, 1, 1, 32'h300, 1, 0,  0, 32'h208, 1, d(32'h200),    32'h204, 1);
    tbl[17] = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h300, 0, 32'h0,         32'h0,   0);
    tbl[18] = row(0, 1, 0, 32'h0,   0, 0,  1, 32'h304, 1, d(32'h300),    32'h304, 1);
    tbl[19] = row(0, 0, 0, 32'h0,   0, 0,  1, 32'h304, 1, d(32'h300),    32'h304, 1);
    tbl[20] = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h304, 0, 32'h0,         32'h0,   0);
    tbl[21] = row(0, 0, 1, 32'h400, 0, 0,  1, 32'h308, 1, d(32'h304),    32'h308, 1);
    tbl[22] = row(1, 0, 0, 32'h0,   1, 1,  0, 32'h308, 0, 32'h0,         32'h0,   0);
    tbl[23] = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h0,   0, 32'h0,         32'h0,   1);
    tbl[24] = row(0, 0, 0, 32'h0,   1, 0,  1, 32'h4,   1, d(32'h0),      32'h4,   1);

    reset = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
    ack_gate = 1'b0; force_ack = 1'b0;
    tick();

    for (int i = 0; i < 25; i++) begin
      reset = tbl[i].rst; stall = tbl[i].st; branch = tbl[i].br;
      target = tbl[i].tgt; ack_gate = tbl[i].ackg; force_ack = tbl[i].fack;
      #1;
      chk("req",   i, {31'd0, req},   {31'd0, tbl[i].e_req});
      chk("addr",  i, addr,           tbl[i].e_addr);
      chk("valid", i, {31'd0, valid}, {31'd0, tbl[i].e_valid});
      chk("instr", i, instr,          tbl[i].e_instr);
      if (tbl[i].c_pc4) chk("pc4", i, pc4, tbl[i].e_pc4);
      tick();
    end

    // DRAIN: a second branch arriving with the ack wins over the first.
    reset = 1'b0; force_ack = 1'b0; stall = 1'b0;
    ack_gate = 1'b0; branch = 1'b1; target = 32'h500;   // at addr 0x8
    #1; chk("drain_enter_addr", 100, addr, 32'h8);
    tick();
    ack_gate = 1'b1; branch = 1'b1; target = 32'h600; stall = 1'b1;
    #1;
    chk("drain_req",   101, {31'd0, req},   32'd1);
    chk("drain_addr",  101, addr,           32'h8);
    chk("drain_valid", 101, {31'd0, valid}, 32'd0);
    tick();
    branch = 1'b0; stall = 1'b0;
    #1;
    chk("redir_addr",  102, addr,           32'h600);
    chk("redir_valid", 102, {31'd0, valid}, 32'd0);
    tick();
    #1;
    chk("redir_instr", 103, instr, d(32'h600));
    chk("redir_pc4",   103, pc4,   32'h604);

    // PC wrap on the second instance, reset to 0xFFFF_FFFC.
    reset = 1'b1;
    tick();
    reset = 1'b0; ack_gate = 1'b1;
    #1;
    chk("wrap_req",   110, {31'd0, req2},   32'd1);
    chk("wrap_addr",  110, addr2,           32'hFFFF_FFFC);
    chk("wrap_valid", 110, {31'd0, valid2}, 32'd0);
    tick();
    chk("wrap_pc4",    111, pc42,            32'h0);
    chk("wrap_instr",  111, instr2,          32'h5A5A_FFFC);
    chk("wrap_valid1", 111, {31'd0, valid2}, 32'd1);
    chk("wrap_next",   111, addr2,           32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
